// File: rtl/register_file_sb.sv
// DEPTH x W register file with two async read ports, one sync write port and a busy scoreboard.
// Define RF_BYPASS_EN for a same-cycle write-to-read bypass on both read ports.
module register_file_sb #(
  parameter int unsigned W       = 32,
  parameter int unsigned DEPTH   = 16,
  parameter bit          ZERO_R0 = 1'b0,
  localparam int unsigned AW     = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_data,
  input  logic [AW-1:0] rs1,
  input  logic [AW-1:0] rs2,
  output logic [W-1:0]  out1,
  output logic [W-1:0]  out2,
  input  logic          rsv_en,
  input  logic [AW-1:0] rsv_addr,
  output logic          busy1,
  output logic          busy2,
  output logic [AW:0]   busy_cnt
);

  localparam logic [AW:0] DepthW = (AW + 1)'(DEPTH);

  logic [W-1:0]     regs_q [DEPTH];
  logic [DEPTH-1:0] busy_q;
  logic [AW:0]      cnt_q;

  logic wr_ok, rsv_ok, rd1_ok, rd2_ok;
  logic set_new, clr_new;

  // Address names a real register that is not the hardwired zero.
  function automatic logic addr_ok(logic [AW-1:0] a);
    return ({1'b0, a} < DepthW) && !(ZERO_R0 && (a == '0));
  endfunction

  assign wr_ok  = we && addr_ok(wr_addr);
  assign rsv_ok = rsv_en && addr_ok(rsv_addr);
  assign rd1_ok = addr_ok(rs1);
  assign rd2_ok = addr_ok(rs2);

  // A same-address reservation overrides the write-back's clear.
  assign set_new = rsv_ok && !busy_q[rsv_addr];
  assign clr_new = wr_ok && busy_q[wr_addr] && !(rsv_ok && (rsv_addr == wr_addr));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        regs_q[i] <= '0;
      end
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (wr_ok) begin
        regs_q[wr_addr] <= wr_data;
        busy_q[wr_addr] <= 1'b0;
      end
      if (rsv_ok) begin
        busy_q[rsv_addr] <= 1'b1;
      end
      cnt_q <= cnt_q + (AW + 1)'(set_new) - (AW + 1)'(clr_new);
    end
  end

  always_comb begin
    out1  = '0;
    busy1 = 1'b0;
    if (rd1_ok) begin
      out1  = regs_q[rs1];
      busy1 = busy_q[rs1];
    end
`ifdef RF_BYPASS_EN
    if (wr_ok && (wr_addr == rs1)) begin
      out1  = wr_data;
      busy1 = rsv_ok && (rsv_addr == rs1);
    end
`endif
  end

  always_comb begin
    out2  = '0;
    busy2 = 1'b0;
    if (rd2_ok) begin
      out2  = regs_q[rs2];
      busy2 = busy_q[rs2];
    end
`ifdef RF_BYPASS_EN
    if (wr_ok && (wr_addr == rs2)) begin
      out2  = wr_data;
      busy2 = rsv_ok && (rsv_addr == rs2);
    end
`endif
  end

  assign busy_cnt = cnt_q;

endmodule

// File: tb/tb_register_file_sb.sv
// Self-checking bench for register_file_sb: a 16-entry instance with hardwired r0 and a
// 12-entry 16-bit instance, directed steps plus a model-driven random phase on the first.
module tb_register_file_sb;

`ifdef RF_BYPASS_EN
  localparam bit Byp = 1'b1;
`else
  localparam bit Byp = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  // Instance A: DEPTH 16, W 32, ZERO_R0 1
  logic        a_we, a_re, a_busy1, a_busy2;
  logic [3:0]  a_wa, a_rs1, a_rs2, a_ra;
  logic [31:0] a_wd, a_out1, a_out2;
  logic [4:0]  a_cnt;

  // Instance B: DEPTH 12, W 16, ZERO_R0 0
  logic        b_we, b_re, b_busy1, b_busy2;
  logic [3:0]  b_wa, b_rs1, b_rs2, b_ra;
  logic [15:0] b_wd, b_out1, b_out2;
  logic [4:0]  b_cnt;

  register_file_sb #(.W(32), .DEPTH(16), .ZERO_R0(1'b1)) u_a (
    .clock(clock), .reset(reset), .we(a_we), .wr_addr(a_wa), .wr_data(a_wd),
    .rs1(a_rs1), .rs2(a_rs2), .out1(a_out1), .out2(a_out2), .rsv_en(a_re),
    .rsv_addr(a_ra), .busy1(a_busy1), .busy2(a_busy2), .busy_cnt(a_cnt)
  );

  register_file_sb #(.W(16), .DEPTH(12), .ZERO_R0(1'b0)) u_b (
    .clock(clock), .reset(reset), .we(b_we), .wr_addr(b_wa), .wr_data(b_wd),
    .rs1(b_rs1), .rs2(b_rs2), .out1(b_out1), .out2(b_out2), .rsv_en(b_re),
    .rsv_addr(b_ra), .busy1(b_busy1), .busy2(b_busy2), .busy_cnt(b_cnt)
  );

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  logic [31:0] m_reg [16];
  logic [15:0] m_busy;

  task automatic push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sbq.push_back(e);
  endtask

  task automatic pop_chk(input logic [31:0] obs);
    exp_t e;
    checks++;
    if (sbq.size() == 0) begin
      errors++;
      $error("FAIL sb_underflow: observed %h with no expected value queued", obs);
    end else begin
      e = sbq.pop_front();
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    #1;
    reset = 1'b0;
    #1;
  endtask

  // Expected {busy, data} on port A for read address rs, given current stimulus.
  function automatic logic [32:0] model_rd(input logic [3:0] rs);
    logic [32:0] r;
    r = (rs == 4'd0) ? 33'd0 : {m_busy[rs], m_reg[rs]};
    if (Byp && a_we && (a_wa == rs) && (a_wa != 4'd0)) r = {a_re && (a_ra == rs), a_wd};
    return r;
  endfunction

  initial begin
    logic [32:0] r1, r2;
    reset = 1'b1;
    {a_we, a_re, a_wa, a_rs1, a_rs2, a_ra, a_wd} = '0;
    {b_we, b_re, b_wa, b_rs1, b_rs2, b_ra, b_wd} = '0;
    #12;
    reset = 1'b0;
    #1;
    push("rst_out1", 32'd0);   pop_chk(a_out1);
    push("rst_busy1", 32'd0);  pop_chk(32'(a_busy1));
    push("rst_cnt", 32'd0);    pop_chk(32'(a_cnt));

    // Async reset clears state before the next edge
    a_we = 1'b1; a_wa = 4'd5; a_wd = 32'hDEADBEEF; a_re = 1'b1; a_ra = 4'd9;
    tick();
    a_we = 1'b0; a_re = 1'b0; a_rs1 = 4'd5;
    #1;
    push("t1_out_pre", 32'hDEADBEEF); pop_chk(a_out1);
    push("t1_cnt_pre", 32'd1);        pop_chk(32'(a_cnt));
    reset = 1'b1;
    #1;
    push("t1_out_rst", 32'd0); pop_chk(a_out1);
    push("t1_cnt_rst", 32'd0); pop_chk(32'(a_cnt));
    reset = 1'b0;
    #1;

    // Write latency / bypass
    a_we = 1'b1; a_wa = 4'd3; a_wd = 32'h12345678; a_rs1 = 4'd3;
    #1;
    push("t2_same_cycle", Byp ? 32'h12345678 : 32'd0); pop_chk(a_out1);
    tick();
    a_we = 1'b0;
    #1;
    push("t2_next_cycle", 32'h12345678); pop_chk(a_out1);

    // Reserve then write-back
    a_re = 1'b1; a_ra = 4'd7; a_rs1 = 4'd7;
    tick();
    a_re = 1'b0;
    #1;
    push("t3_busy_set", 32'd1); pop_chk(32'(a_busy1));
    push("t3_cnt_set", 32'd1);  pop_chk(32'(a_cnt));
    a_we = 1'b1; a_wa = 4'd7; a_wd = 32'h1;
    tick();
    a_we = 1'b0;
    #1;
    push("t3_busy_clr", 32'd0); pop_chk(32'(a_busy1));
    push("t3_cnt_clr", 32'd0);  pop_chk(32'(a_cnt));

    // Same-address write+reserve, then different-address write+reserve
    a_re = 1'b1; a_ra = 4'd4;
    tick();
    a_we = 1'b1; a_wa = 4'd4; a_wd = 32'hA5A5A5A5;
    tick();
    a_we = 1'b0; a_re = 1'b0; a_rs1 = 4'd4;
    #1;
    push("t4_data", 32'hA5A5A5A5); pop_chk(a_out1);
    push("t4_busy", 32'd1);        pop_chk(32'(a_busy1));
    push("t4_cnt", 32'd1);         pop_chk(32'(a_cnt));
    a_we = 1'b1; a_wa = 4'd4; a_wd = 32'h0BADF00D; a_re = 1'b1; a_ra = 4'd6; a_rs2 = 4'd6;
    tick();
    a_we = 1'b0; a_re = 1'b0;
    #1;
    push("t4b_busy4", 32'd0); pop_chk(32'(a_busy1));
    push("t4b_busy6", 32'd1); pop_chk(32'(a_busy2));
    push("t4b_cnt", 32'd1);   pop_chk(32'(a_cnt));
    push("t4b_data", 32'h0BADF00D); pop_chk(a_out1);

    // Hardwired r0
    pulse_reset();
    a_we = 1'b1; a_wa = 4'd0; a_wd = 32'hFFFFFFFF; a_re = 1'b1; a_ra = 4'd0; a_rs1 = 4'd0;
    #1;
    push("t5_out_pre", 32'd0); pop_chk(a_out1);
    tick();
    a_we = 1'b0; a_re = 1'b0;
    #1;
    push("t5_out", 32'd0);  pop_chk(a_out1);
    push("t5_busy", 32'd0); pop_chk(32'(a_busy1));
    push("t5_cnt", 32'd0);  pop_chk(32'(a_cnt));

    // Random phase against a reference model
    pulse_reset();
    m_busy = '0;
    for (int i = 0; i < 16; i++) m_reg[i] = '0;
    for (int n = 0; n < 300; n++) begin
      a_we  = ($urandom_range(0, 2) != 0);
      a_wa  = 4'($urandom_range(0, 15));
      a_wd  = $urandom;
      a_re  = ($urandom_range(0, 2) == 0);
      a_ra  = 4'($urandom_range(0, 15));
      a_rs1 = 4'($urandom_range(0, 15));
      a_rs2 = (n % 4 == 0) ? a_wa : 4'($urandom_range(0, 15));
      r1 = model_rd(a_rs1);
      r2 = model_rd(a_rs2);
      push("rnd_out1", r1[31:0]);        push("rnd_busy1", 32'(r1[32]));
      push("rnd_out2", r2[31:0]);        push("rnd_busy2", 32'(r2[32]));
      #1;
      pop_chk(a_out1); pop_chk(32'(a_busy1));
      pop_chk(a_out2); pop_chk(32'(a_busy2));
      if (a_we && a_wa != 4'd0) begin
        m_reg[a_wa]  = a_wd;
        m_busy[a_wa] = 1'b0;
      end
      if (a_re && a_ra != 4'd0) m_busy[a_ra] = 1'b1;
      push("rnd_cnt", 32'($countones(m_busy)));
      tick();
      pop_chk(32'(a_cnt));
    end
    a_we = 1'b0; a_re = 1'b0;

    // DEPTH=12: out-of-range accesses, full reservation
    pulse_reset();
    b_we = 1'b1; b_wa = 4'd13; b_wd = 16'hABCD; b_rs2 = 4'd13;
    #1;
    push("t6_out2_pre", 32'd0);  pop_chk(32'(b_out2));
    push("t6_busy2_pre", 32'd0); pop_chk(32'(b_busy2));
    tick();
    b_we = 1'b0;
    #1;
    push("t6_out2", 32'd0); pop_chk(32'(b_out2));
    for (int i = 0; i < 12; i++) begin
      b_rs1 = 4'(i);
      #1;
      push("t6_untouched", 32'd0); pop_chk(32'(b_out1));
    end
    for (int i = 0; i < 12; i++) begin
      b_re = 1'b1; b_ra = 4'(i);
      tick();
    end
    b_ra = 4'd14;
    tick();
    b_re = 1'b0; b_rs1 = 4'd11; b_rs2 = 4'd13;
    #1;
    push("t6_cnt_full", 32'd12); pop_chk(32'(b_cnt));
    push("t6_busy11", 32'd1);    pop_chk(32'(b_busy1));
    push("t6_busy13", 32'd0);    pop_chk(32'(b_busy2));
    for (int i = 0; i < 12; i++) begin
      b_we = 1'b1; b_wa = 4'(i); b_wd = 16'(i * 3 + 1);
      tick();
    end
    b_we = 1'b0;
    #1;
    push("t6_cnt_drain", 32'd0); pop_chk(32'(b_cnt));
    push("t6_data11", 32'd34);   pop_chk(32'(b_out1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
